mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester (IF, read-only) and the data-memory requester (DM, read/write).
- Sits between the CPU's PC/fetch logic and load/store logic on one side, and the memory macro on the other.
- Serialises accesses, sequences the memory's fixed read latency, and returns data with a one-cycle ack pulse to the requester that was granted.

Parameters:
- LAT, 4, memory read latency in cycles from the issue cycle to valid mem_rdata; legal range 1..15.
- AW, 16, address width.
- DW, 16, data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  IF access request, level; held until if_ack.
- if_addr  in  AW  IF read address; stable while if_req is high.
- if_ack  out  1  one-cycle pulse; if_data is valid in this cycle.
- if_data  out  DW  registered IF read data.
- dm_req  in  1  DM access request, level; held until dm_ack.
- dm_we  in  1  1 = write, 0 = read; stable while dm_req is high.
- dm_addr  in  AW  DM address.
- dm_wdata  in  DW  DM write data.
- dm_ack  out  1  one-cycle completion pulse.
- dm_rdata  out  DW  registered DM read data.
- mem_en  out  1  memory command strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid in issue cycle + LAT.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; all outputs 0, including if_data and dm_rdata.
  - Any in-flight transaction is dropped with no ack.
  - Requests are ignored while rst is high.
- FSM states:
  - IDLE: evaluate requests at the clock edge. If any request is granted: latch owner, address, we and wdata; next state is ISSUE. If no request, stay in IDLE.
  - ISSUE (exactly 1 cycle):
    - mem_en = 1; mem_addr and mem_wdata come from the latched registers.
    - mem_we = 1 only for a DM write.
    - Load the cycle counter (4 bits) with LAT-1; next state is WAIT.
  - WAIT:
    - mem_en = 0 and mem_we = 0.
    - When cnt != 0: cnt decrements each cycle.
    - When cnt == 0: capture mem_rdata into the owner's data register (reads only); next state is RESP.
    - WAIT therefore lasts exactly LAT cycles.
  - RESP (1 cycle):
    - Owner's ack = 1; next state is IDLE.
    - No grant is made in RESP. The requester must drop req at the edge that ends its ack cycle.
- Latency:
  - Request high in IDLE cycle t → ISSUE in cycle t+1 → ack in cycle t+LAT+2.
  - A back-to-back next grant is sampled in the IDLE cycle that follows RESP.
- Writes:
  - dm_ack is generated with the same timing as a read.
  - dm_rdata is unchanged by a write.
  - if_data changes only on IF completions; dm_rdata changes only on DM read completions.
- Arbitration, fixed priority (default): when both requests are high in IDLE, DM wins.
- mem_addr and mem_wdata hold their last value outside ISSUE.
- Requests that arrive while busy are held by the requester and evaluated in the next IDLE cycle.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - A last_grant register records the owner of the most recent grant and resets to IF.
  - On a tie, the requester that is not last_grant wins, so the first tie goes to DM and ties then alternate.
  - A single pending request is always granted, regardless of last_grant.
- Undefined: fixed DM priority. The last_grant register is not present.

Test Plan:
- LAT=4, IF read: if_req=1, if_addr=0x0010 in cycle 0; the memory model drives 0xBEEF in cycle 5 → mem_en=1 and mem_addr=0x0010 in cycle 1 only; if_ack=1 and if_data=0xBEEF in cycle 6; busy=1 in cycles 1-6.
- DM write: dm_req=1, dm_we=1, dm_addr=0x0100, dm_wdata=0x1234 in cycle 0 → mem_en=1, mem_we=1, mem_wdata=0x1234 in cycle 1; dm_ack in cycle 6; dm_rdata unchanged; if_ack remains 0.
- Tie, fixed priority: if_req and dm_req (read of 0x0200) both high in cycle 0 → DM issued in cycle 1, dm_ack in cycle 6; IF sampled in cycle 7, issued in cycle 8, if_ack in cycle 13.
- Tie, MEM_ARB_RR_EN defined: both requesters re-request immediately after each ack → grant order DM, IF, DM, IF. With the macro undefined and dm_req held → DM, DM, with IF starved.
- Reset mid-WAIT: IF read starts in cycle 0; rst=1 in cycle 3 → all outputs 0 immediately, no ack ever; rst=0 in cycle 5, new request in cycle 6 → ack in cycle 12.
- LAT=1: dm read request in cycle 0, memory data 0x00FF valid in cycle 2 → ISSUE in cycle 1, WAIT in cycle 2, dm_ack=1 and dm_rdata=0x00FF in cycle 3.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: IF and DM request/response channels plus the memory
// command/data bus. slave is the arbiter side, master the CPU/memory side.
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_data;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ack, if_data, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ack, if_data, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises IF and DM accesses onto one fixed-latency single-ported memory.
// Ties go to DM; define MEM_ARB_RR_EN to alternate ties between the requesters.
module mem_arbiter #(
    parameter int LAT = 4,
    parameter int AW  = 16,
    parameter int DW  = 16
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t        state, state_nxt;
    owner_t        owner, grant_owner;
    logic          grant;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] if_data_q;
    logic [DW-1:0] dm_rdata_q;
    logic [3:0]    cnt;
`ifdef MEM_ARB_RR_EN
    owner_t        last_grant;
`endif

    always_comb begin
        grant       = bus.if_req | bus.dm_req;
        grant_owner = bus.dm_req ? OWN_DM : OWN_IF;
`ifdef MEM_ARB_RR_EN
        if (bus.if_req && bus.dm_req)
            grant_owner = (last_grant == OWN_IF) ? OWN_DM : OWN_IF;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        bus.mem_en = 1'b0;
        bus.mem_we = 1'b0;
        bus.if_ack = 1'b0;
        bus.dm_ack = 1'b0;
        case (state)
            IDLE:  if (grant) state_nxt = ISSUE;
            ISSUE: begin
                bus.mem_en = 1'b1;
                bus.mem_we = we_q;
                state_nxt  = WAIT;
            end
            WAIT:  if (cnt == '0) state_nxt = RESP;
            RESP: begin
                bus.if_ack = (owner == OWN_IF);
                bus.dm_ack = (owner == OWN_DM);
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Data registers clear on reset too, so a dropped transaction leaves nothing visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt        <= '0;
            if_data_q  <= '0;
            dm_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (grant) begin
                    owner <= grant_owner;
                    if (grant_owner == OWN_DM) begin
                        addr_q  <= bus.dm_addr;
                        we_q    <= bus.dm_we;
                        wdata_q <= bus.dm_wdata;
                    end else begin
                        addr_q  <= bus.if_addr;
                        we_q    <= 1'b0;
                    end
                end
                ISSUE: cnt <= CNT_INIT;
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else if (!we_q) begin
                        if (owner == OWN_IF) if_data_q  <= bus.mem_rdata;
                        else                 dm_rdata_q <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        last_grant <= OWN_IF;
        else if (state == IDLE && grant) last_grant <= grant_owner;
    end
`endif

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_data   = if_data_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, reset/tie/fairness
// sequences, a LAT=1 instance, and a randomized run against a transaction-level model.
module tb_mem_arbiter;
    localparam int LAT   = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int NRAND = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus4 ();
    mem_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();

    mem_arbiter #(.LAT(LAT), .AW(AW), .DW(DW)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    mem_arbiter #(.LAT(1),   .AW(AW), .DW(DW)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] env_mem [0:65535];
    logic [15:0] ref_mem [0:65535];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory macro model for the LAT=4 instance: data appears only in issue cycle + LAT.
    bit          rd_pending = 1'b0;
    int          rd_due;
    logic [15:0] rd_val;
    always @(negedge clk) begin
        if (rd_pending && cyc == rd_due) begin
            bus4.mem_rdata = rd_val;
            rd_pending     = 1'b0;
        end else begin
            bus4.mem_rdata = 16'($urandom);
        end
        if (bus4.mem_en) begin
            if (bus4.mem_we) begin
                env_mem[bus4.mem_addr] = bus4.mem_wdata;
            end else begin
                rd_pending = 1'b1;
                rd_due     = cyc + LAT;
                rd_val     = env_mem[bus4.mem_addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic chk_w(input string name, input logic [15:0] act, input logic [15:0] exp);
        check(name, {16'b0, act}, {16'b0, exp});
    endtask

    task automatic chk_ctrl(input string tag, input int c, input logic e_busy, input logic e_en,
                            input logic e_we, input logic e_ia, input logic e_da);
        chk_bit($sformatf("%s c%0d busy", tag, c),   bus4.busy,   e_busy);
        chk_bit($sformatf("%s c%0d mem_en", tag, c), bus4.mem_en, e_en);
        chk_bit($sformatf("%s c%0d mem_we", tag, c), bus4.mem_we, e_we);
        chk_bit($sformatf("%s c%0d if_ack", tag, c), bus4.if_ack, e_ia);
        chk_bit($sformatf("%s c%0d dm_ack", tag, c), bus4.dm_ack, e_da);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          dm;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        bit          pre;
        logic [15:0] pre_val;
        logic [15:0] exp_data;
    } vec_t;

    vec_t        vecs [6];
    vec_t        t;
    logic [15:0] exp_if, exp_dm, exp_addr;
    bit          got_dm [8];
    bit          exp_order_dm [4];
    int          n_grants;
    // reference-model state for the random phase
    bit          txn_valid, m_dm, m_we, m_last_dm, addr_known, pick_dm, if_drop, dm_drop;
    logic [15:0] m_addr, m_wdata, m_rdata;
    int          iss_cyc, ack_cyc, free_cyc;

    initial begin
        // owner data register after the access: read data, or the unchanged dm_rdata for writes
        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b1, 16'h0100, 16'h1234, 1'b0, 16'h0000, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 16'h0000, 16'h1234};
        vecs[3] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0001, 16'h0001};
        vecs[4] = '{1'b1, 1'b1, 16'h0010, 16'hA5A5, 1'b0, 16'h0000, 16'h1234};
        vecs[5] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 16'hA5A5};
`ifdef MEM_ARB_RR_EN
        exp_order_dm = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_order_dm = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int i = 0; i < 65536; i++) begin
            env_mem[i] = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
        {bus4.if_req, bus4.dm_req, bus4.dm_we} = 3'b000;
        bus4.if_addr = '0; bus4.dm_addr = '0; bus4.dm_wdata = '0;
        {bus1.if_req, bus1.dm_req, bus1.dm_we} = 3'b000;
        bus1.if_addr = '0; bus1.dm_addr = '0; bus1.dm_wdata = '0;
        bus1.mem_rdata = 16'hDEAD;

        // ---- reset state ----
        @(posedge clk); @(negedge clk);
        chk_ctrl("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_w("reset if_data", bus4.if_data, 16'h0);
        chk_w("reset dm_rdata", bus4.dm_rdata, 16'h0);
        chk_w("reset mem_addr", bus4.mem_addr, 16'h0);
        chk_w("reset mem_wdata", bus4.mem_wdata, 16'h0);
        chk_bit("reset lat1 busy", bus1.busy, 1'b0);
        chk_bit("reset lat1 dm_ack", bus1.dm_ack, 1'b0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        exp_if = 16'h0;
        exp_dm = 16'h0;

        // ---- single-transaction vector table ----
        for (int v = 0; v < 6; v++) begin
            t = vecs[v];
            if (t.pre) env_mem[t.addr] = t.pre_val;
            if (t.dm) begin
                bus4.dm_req = 1'b1; bus4.dm_we = t.we; bus4.dm_addr = t.addr; bus4.dm_wdata = t.wdata;
            end else begin
                bus4.if_req = 1'b1; bus4.if_addr = t.addr;
            end
            for (int c = 0; c <= LAT + 3; c++) begin
                @(negedge clk);
                chk_ctrl($sformatf("vec%0d", v), c, (c >= 1 && c <= LAT + 2), (c == 1),
                         (c == 1 && t.we), (c == LAT + 2 && !t.dm), (c == LAT + 2 && t.dm));
                if (c == 1) begin
                    chk_w($sformatf("vec%0d mem_addr", v), bus4.mem_addr, t.addr);
                    if (t.we) chk_w($sformatf("vec%0d mem_wdata", v), bus4.mem_wdata, t.wdata);
                end
                if (c == LAT + 2) begin
                    if (t.dm) exp_dm = t.exp_data;
                    else      exp_if = t.exp_data;
                    chk_w($sformatf("vec%0d mem_addr hold", v), bus4.mem_addr, t.addr);
                end
                chk_w($sformatf("vec%0d c%0d if_data", v, c), bus4.if_data, exp_if);
                chk_w($sformatf("vec%0d c%0d dm_rdata", v, c), bus4.dm_rdata, exp_dm);
                next_cycle();
                if (c == LAT + 2) begin
                    bus4.if_req = 1'b0;
                    bus4.dm_req = 1'b0;
                end
            end
            if (t.we) chk_w($sformatf("vec%0d memory write", v), env_mem[t.addr], t.wdata);
        end

        // ---- reset in the middle of WAIT ----
        env_mem[16'h0040] = 16'h4444;
        env_mem[16'h0050] = 16'h5050;
        bus4.if_req = 1'b1; bus4.if_addr = 16'h0040;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_bit($sformatf("rstwait c%0d busy", c), bus4.busy, (c >= 1));
            next_cycle();
        end
        rst = 1'b1;
        bus4.if_req = 1'b0;
        #1;
        chk_ctrl("rst async", 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_w("rst async if_data", bus4.if_data, 16'h0);
        chk_w("rst async dm_rdata", bus4.dm_rdata, 16'h0);
        chk_w("rst async mem_addr", bus4.mem_addr, 16'h0);
        chk_w("rst async mem_wdata", bus4.mem_wdata, 16'h0);
        exp_if = 16'h0;
        exp_dm = 16'h0;
        for (int c = 3; c <= 13; c++) begin
            if (c == 5) rst = 1'b0;
            if (c == 6) begin bus4.if_req = 1'b1; bus4.if_addr = 16'h0050; end
            @(negedge clk);
            chk_ctrl("rstwait", c, (c >= 7 && c <= 12), (c == 7), 1'b0, (c == 12), 1'b0);
            if (c == 12) begin
                exp_if = 16'h5050;
                chk_w("rstwait if_data", bus4.if_data, exp_if);
            end
            next_cycle();
            if (c == 12) bus4.if_req = 1'b0;
        end

        // ---- simultaneous requests ----
        env_mem[16'h0200] = 16'h7777;
        env_mem[16'h0300] = 16'h3333;
        bus4.dm_req = 1'b1; bus4.dm_we = 1'b0; bus4.dm_addr = 16'h0200;
        bus4.if_req = 1'b1; bus4.if_addr = 16'h0300;
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            chk_ctrl("tie", c, ((c >= 1 && c <= 6) || (c >= 8 && c <= 13)), (c == 1 || c == 8),
                     1'b0, (c == 13), (c == 6));
            if (c == 1) chk_w("tie dm mem_addr", bus4.mem_addr, 16'h0200);
            if (c == 8) chk_w("tie if mem_addr", bus4.mem_addr, 16'h0300);
            if (c == 6) begin exp_dm = 16'h7777; chk_w("tie dm_rdata", bus4.dm_rdata, exp_dm); end
            if (c == 13) begin exp_if = 16'h3333; chk_w("tie if_data", bus4.if_data, exp_if); end
            next_cycle();
            if (c == 6)  bus4.dm_req = 1'b0;
            if (c == 13) bus4.if_req = 1'b0;
        end

        // ---- both requesters held: fairness vs. DM priority ----
        env_mem[16'h0A00] = 16'h0A0A;
        env_mem[16'h0B00] = 16'h0B0B;
        bus4.dm_req = 1'b1; bus4.dm_we = 1'b0; bus4.dm_addr = 16'h0A00;
        bus4.if_req = 1'b1; bus4.if_addr = 16'h0B00;
        n_grants = 0;
        for (int c = 0; c <= 27; c++) begin
            @(negedge clk);
            if (bus4.mem_en) begin
                if (n_grants < 8) got_dm[n_grants] = (bus4.mem_addr == 16'h0A00);
                n_grants++;
            end
            next_cycle();
        end
        bus4.dm_req = 1'b0;
        bus4.if_req = 1'b0;
        check("held grants count", n_grants, 4);
        for (int i = 0; i < 4; i++)
            chk_bit($sformatf("held grant%0d is DM", i), got_dm[i], exp_order_dm[i]);
        for (int c = 0; c < 6; c++) next_cycle();
        @(negedge clk);
        exp_dm = 16'h0A0A;
`ifdef MEM_ARB_RR_EN
        exp_if = 16'h0B0B;
`endif
        chk_bit("held idle busy", bus4.busy, 1'b0);
        chk_w("held dm_rdata", bus4.dm_rdata, exp_dm);
        chk_w("held if_data", bus4.if_data, exp_if);
        next_cycle();

        // ---- LAT=1 instance ----
        bus1.dm_req = 1'b1; bus1.dm_we = 1'b0; bus1.dm_addr = 16'h0022;
        for (int c = 0; c <= 4; c++) begin
            bus1.mem_rdata = (c == 2) ? 16'h00FF : 16'hDEAD;
            @(negedge clk);
            chk_bit($sformatf("lat1 c%0d busy", c), bus1.busy, (c >= 1 && c <= 3));
            chk_bit($sformatf("lat1 c%0d mem_en", c), bus1.mem_en, (c == 1));
            chk_bit($sformatf("lat1 c%0d dm_ack", c), bus1.dm_ack, (c == 3));
            if (c == 1) chk_w("lat1 mem_addr", bus1.mem_addr, 16'h0022);
            if (c == 3) chk_w("lat1 dm_rdata", bus1.dm_rdata, 16'h00FF);
            next_cycle();
            if (c == 3) bus1.dm_req = 1'b0;
        end

        // ---- randomized traffic against a transaction-level model ----
        for (int a = 16'h1000; a < 16'h1010; a++) begin
            env_mem[a] = 16'($urandom);
            ref_mem[a] = env_mem[a];
        end
        txn_valid = 1'b0; addr_known = 1'b0; if_drop = 1'b0; dm_drop = 1'b0;
        m_last_dm = 1'b0;  // most recent grant before this phase went to IF under round-robin
        iss_cyc = -1; ack_cyc = -1; free_cyc = 0;
        m_dm = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0; exp_addr = '0;
        for (int rc = 0; rc < NRAND; rc++) begin
            if (if_drop) begin
                bus4.if_req = 1'b0; if_drop = 1'b0;
            end else if (!bus4.if_req && rc < NRAND - 20 && $urandom_range(0, 2) == 0) begin
                bus4.if_req = 1'b1; bus4.if_addr = 16'h1000 + 16'($urandom_range(0, 15));
            end
            if (dm_drop) begin
                bus4.dm_req = 1'b0; dm_drop = 1'b0;
            end else if (!bus4.dm_req && rc < NRAND - 20 && $urandom_range(0, 2) == 0) begin
                bus4.dm_req   = 1'b1;
                bus4.dm_we    = 1'($urandom_range(0, 1));
                bus4.dm_addr  = 16'h1000 + 16'($urandom_range(0, 15));
                bus4.dm_wdata = 16'($urandom);
            end
            @(negedge clk);
            if (txn_valid && rc == ack_cyc && !m_we) begin
                if (m_dm) exp_dm = m_rdata;
                else      exp_if = m_rdata;
            end
            chk_ctrl("rand", rc, txn_valid && rc >= iss_cyc && rc <= ack_cyc,
                     txn_valid && rc == iss_cyc, txn_valid && rc == iss_cyc && m_we,
                     txn_valid && rc == ack_cyc && !m_dm, txn_valid && rc == ack_cyc && m_dm);
            chk_w($sformatf("rand c%0d if_data", rc), bus4.if_data, exp_if);
            chk_w($sformatf("rand c%0d dm_rdata", rc), bus4.dm_rdata, exp_dm);
            if (addr_known) chk_w($sformatf("rand c%0d mem_addr", rc), bus4.mem_addr, exp_addr);
            if (txn_valid && rc == iss_cyc && m_we)
                chk_w($sformatf("rand c%0d mem_wdata", rc), bus4.mem_wdata, m_wdata);
            if (txn_valid && rc == ack_cyc) begin
                if (m_dm) dm_drop = 1'b1;
                else      if_drop = 1'b1;
            end
            // the arbiter samples requests at the end of any cycle in which it is free
            if (rc >= free_cyc && (bus4.if_req || bus4.dm_req)) begin
`ifdef MEM_ARB_RR_EN
                pick_dm = (bus4.if_req && bus4.dm_req) ? !m_last_dm : bus4.dm_req;
`else
                pick_dm = bus4.dm_req;
`endif
                txn_valid = 1'b1;
                m_dm      = pick_dm;
                m_we      = pick_dm && bus4.dm_we;
                m_addr    = pick_dm ? bus4.dm_addr : bus4.if_addr;
                m_wdata   = bus4.dm_wdata;
                iss_cyc   = rc + 1;
                ack_cyc   = rc + LAT + 2;
                free_cyc  = rc + LAT + 3;
                if (m_we) ref_mem[m_addr] = m_wdata;
                else      m_rdata = ref_mem[m_addr];
                exp_addr   = m_addr;
                addr_known = 1'b1;
                m_last_dm  = pick_dm;
            end
            next_cycle();
        end
        chk_bit("rand end idle", bus4.busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
